// File: rtl/lebug_pkg.sv
// Shared types for the trace-path blocks: pack mode encoding and element type.
package lebug_pkg;

  // Default element width used by blocks on the trace path.
  localparam int ELEM_WIDTH = 32;

  typedef logic [ELEM_WIDTH-1:0] elem_t;

  // Elements per input: PACK_N = full vector, PACK_M = M elements, PACK_1 = one element.
  typedef enum logic [1:0] {
    PACK_N = 2'd0,
    PACK_M = 2'd1,
    PACK_1 = 2'd2
  } pack_mode_e;

endpackage : lebug_pkg

// File: rtl/data_packer_unit.sv
// Packs zero-padded partial vectors (N, M or 1 useful elements per input) into
// dense N-element vectors. Emits one cycle after the completing input, or on
// end-of-frame with the unfilled tail zero padded.
module data_packer_unit
  import lebug_pkg::pack_mode_e;
  import lebug_pkg::PACK_N;
  import lebug_pkg::PACK_M;
  import lebug_pkg::PACK_1;
#(
  parameter int N          = 8,
  parameter int M          = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           valid_in,
  input  logic                           eof_in,
  input  logic [1:0]                     pack_mode,
  input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
  output logic                           valid_out,
  output logic                           eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]   vector_out
);

  localparam int LW = $clog2(N);  // slot index width
  localparam int PW = LW + 1;     // pointer width, can hold the value N

  // Elements consumed per input in a given mode.
  function automatic logic [PW-1:0] elems(input pack_mode_e m);
    case (m)
      PACK_M:  return PW'(M);
      PACK_1:  return PW'(1);
      default: return PW'(N);
    endcase
  endfunction

  pack_mode_e                       mode_q;
  pack_mode_e                       eff_mode;
  logic [PW-1:0]                    ptr_q;
  logic [PW-1:0]                    p_elems;
  logic [PW-1:0]                    ptr_end;
  logic [N-1:0][DATA_WIDTH-1:0]     buf_q;
  logic [N-1:0][DATA_WIDTH-1:0]     next_buf;
  logic [N-1:0]                     wr_en;
  logic                             complete;
  logic                             emit;

  // Mode in force this cycle: a new pack_mode is only accepted with an empty buffer,
  // so the input arriving at ptr==0 is already packed with the new mode.
  always_comb begin
    // NOTE: default assignment first so every path drives eff_mode; no latch is inferred.
    eff_mode = mode_q;
    if (ptr_q == '0) begin
      case (pack_mode)
        2'd1:    eff_mode = PACK_M;
        2'd2:    eff_mode = PACK_1;
        default: eff_mode = PACK_N;  // 3 is reserved and behaves as pass-through
      endcase
    end
  end

  // Pointer arithmetic and emit decision.
  always_comb begin
    p_elems  = elems(eff_mode);
    ptr_end  = ptr_q + p_elems;  // ptr is a multiple of P, so this never exceeds N
    complete = valid_in && (ptr_end == PW'(N));
    emit     = complete || (eof_in && (valid_in || (ptr_q != '0)));
  end

  // Per-slot write: slot s takes vector_in[s-ptr] when s lies in [ptr, ptr+P).
  for (genvar s = 0; s < N; s++) begin : g_slot
    logic [LW-1:0] src;
    assign src         = LW'(s) - ptr_q[LW-1:0];
    assign wr_en[s]    = valid_in && (PW'(s) >= ptr_q) && (PW'(s) < ptr_end);
    assign next_buf[s] = wr_en[s] ? vector_in[src] : buf_q[s];
  end

  // State and registered outputs; an emit clears the buffer so unfilled slots read as 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the buffer is reset too, because zero padding on flush relies on cleared slots.
      buf_q      <= '0;
      ptr_q      <= '0;
      mode_q     <= PACK_N;
      valid_out  <= 1'b0;
      eof_out    <= 1'b0;
      vector_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      mode_q    <= eff_mode;
      valid_out <= emit;
      eof_out   <= eof_in;
      if (emit) begin
        vector_out <= next_buf;
        buf_q      <= '0;
        ptr_q      <= '0;
      end else if (valid_in) begin
        buf_q <= next_buf;
        ptr_q <= ptr_end;
      end
    end
  end

endmodule : data_packer_unit

// File: tb/tb_data_packer_unit.sv
// Directed, table-driven bench for data_packer_unit (N=8, M=4, DATA_WIDTH=32).
module tb_data_packer_unit;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int DW = 32;

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    logic       vin;
    logic       eof;
    logic [1:0] mode;
    vec_t       din;
    logic       exp_v;
    logic       exp_e;
    vec_t       exp_vec;
  } row_t;

  logic clk = 1'b0;
  logic reset_n;
  logic valid_in;
  logic eof_in;
  logic [1:0] pack_mode;
  vec_t vector_in;
  logic valid_out;
  logic eof_out;
  vec_t vector_out;

  int checks = 0;
  int errors = 0;
  row_t rows[$];

  data_packer_unit #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_in   (valid_in),
    .eof_in     (eof_in),
    .pack_mode  (pack_mode),
    .vector_in  (vector_in),
    .valid_out  (valid_out),
    .eof_out    (eof_out),
    .vector_out (vector_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One useful element at [0]; the rest is junk that must be discarded.
  function automatic vec_t vec1(input int v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = 32'hFF;
    r[0] = v;
    return r;
  endfunction

  function automatic vec_t vec4(input int a, input int b, input int c, input int d);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = 32'hEE;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic vec_t v8(input int a, input int b, input int c, input int d,
                              input int e, input int f, input int g, input int h);
    vec_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    r[4] = e; r[5] = f; r[6] = g; r[7] = h;
    return r;
  endfunction

  function automatic void add(input logic vin, input logic eof, input logic [1:0] mode,
                              input vec_t din, input logic ev, input logic ee, input vec_t evec);
    row_t r;
    r.vin = vin; r.eof = eof; r.mode = mode; r.din = din;
    r.exp_v = ev; r.exp_e = ee; r.exp_vec = evec;
    rows.push_back(r);
  endfunction

  task automatic drive(input logic vin, input logic eof, input logic [1:0] mode, input vec_t din);
    valid_in  = vin;
    eof_in    = eof;
    pack_mode = mode;
    vector_in = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t zero_v;

  initial begin
    zero_v = '0;

    // 1. Mode 2: eight single elements, one output after the eighth.
    for (int i = 1; i <= 7; i++) add(1, 0, 2, vec1(i), 0, 0, zero_v);
    add(1, 0, 2, vec1(8), 1, 0, v8(1, 2, 3, 4, 5, 6, 7, 8));
    add(0, 0, 2, zero_v, 0, 0, zero_v);
    // 2. Mode 1: two four-element inputs.
    add(1, 0, 1, vec4(1, 2, 3, 4), 0, 0, zero_v);
    add(1, 0, 1, vec4(5, 6, 7, 8), 1, 0, v8(1, 2, 3, 4, 5, 6, 7, 8));
    add(0, 0, 1, zero_v, 0, 0, zero_v);
    // Mode 0 and reserved mode 3: registered pass-through.
    add(1, 0, 0, v8(9, 8, 7, 6, 5, 4, 3, 2), 1, 0, v8(9, 8, 7, 6, 5, 4, 3, 2));
    add(1, 0, 3, v8(11, 12, 13, 14, 15, 16, 17, 18), 1, 0, v8(11, 12, 13, 14, 15, 16, 17, 18));
    add(0, 0, 0, zero_v, 0, 0, zero_v);
    // 3. Mode 2, three inputs then eof alone: zero-padded flush.
    add(1, 0, 2, vec1(10), 0, 0, zero_v);
    add(1, 0, 2, vec1(11), 0, 0, zero_v);
    add(1, 0, 2, vec1(12), 0, 0, zero_v);
    add(0, 1, 2, zero_v, 1, 1, v8(10, 11, 12, 0, 0, 0, 0, 0));
    add(0, 0, 2, zero_v, 0, 0, zero_v);
    // 4. eof on empty buffer: marker only; eighth input with eof: one output.
    add(0, 1, 2, zero_v, 0, 1, zero_v);
    for (int i = 21; i <= 27; i++) add(1, 0, 2, vec1(i), 0, 0, zero_v);
    add(1, 1, 2, vec1(28), 1, 1, v8(21, 22, 23, 24, 25, 26, 27, 28));
    add(0, 0, 2, zero_v, 0, 0, zero_v);
    // Mode 1 input together with eof: data written first, then padded flush.
    add(1, 1, 1, vec4(71, 72, 73, 74), 1, 1, v8(71, 72, 73, 74, 0, 0, 0, 0));
    add(0, 0, 1, zero_v, 0, 0, zero_v);
    // 5. Mode change while buffer is partially filled is deferred.
    add(1, 0, 2, vec1(31), 0, 0, zero_v);
    add(1, 0, 2, vec1(32), 0, 0, zero_v);
    for (int i = 33; i <= 37; i++) add(1, 0, 1, vec4(i, 'hAA, 'hAA, 'hAA), 0, 0, zero_v);
    add(1, 0, 1, vec4(38, 'hAA, 'hAA, 'hAA), 1, 0, v8(31, 32, 33, 34, 35, 36, 37, 38));
    add(0, 0, 1, zero_v, 0, 0, zero_v);
    add(1, 0, 1, vec4(41, 42, 43, 44), 0, 0, zero_v);
    add(1, 0, 1, vec4(45, 46, 47, 48), 1, 0, v8(41, 42, 43, 44, 45, 46, 47, 48));
    add(0, 0, 1, zero_v, 0, 0, zero_v);

    // Reset state.
    drive(0, 0, 2'd0, zero_v);
    reset_n = 1'b0;
    #12;
    check("reset_valid_out", N*DW'(valid_out), N*DW'(1'b0));
    check("reset_eof_out", N*DW'(eof_out), N*DW'(1'b0));
    check("reset_vector_out", vector_out, zero_v);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Table-driven section.
    for (int r = 0; r < rows.size(); r++) begin
      drive(rows[r].vin, rows[r].eof, rows[r].mode, rows[r].din);
      step();
      check($sformatf("row%0d_valid_out", r), N*DW'(valid_out), N*DW'(rows[r].exp_v));
      check($sformatf("row%0d_eof_out", r), N*DW'(eof_out), N*DW'(rows[r].exp_e));
      if (rows[r].exp_v)
        check($sformatf("row%0d_vector_out", r), vector_out, rows[r].exp_vec);
    end

    // 6. Asynchronous reset mid-pack discards five buffered elements.
    for (int i = 51; i <= 55; i++) begin
      drive(1, 0, 2'd2, vec1(i));
      step();
      check($sformatf("pre_reset_valid_%0d", i), N*DW'(valid_out), N*DW'(1'b0));
    end
    check("hold_vector_out", vector_out, v8(41, 42, 43, 44, 45, 46, 47, 48));
    drive(0, 0, 2'd2, zero_v);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid_out", N*DW'(valid_out), N*DW'(1'b0));
    check("async_reset_eof_out", N*DW'(eof_out), N*DW'(1'b0));
    check("async_reset_vector_out", vector_out, zero_v);
    #2;
    reset_n = 1'b1;
    for (int i = 61; i <= 68; i++) begin
      drive(1, 0, 2'd2, vec1(i));
      step();
      check($sformatf("post_reset_valid_%0d", i), N*DW'(valid_out), N*DW'(i == 68));
    end
    check("post_reset_vector_out", vector_out, v8(61, 62, 63, 64, 65, 66, 67, 68));
    check("post_reset_eof_out", N*DW'(eof_out), N*DW'(1'b0));
    drive(0, 0, 2'd2, zero_v);
    step();
    check("post_reset_pulse_end", N*DW'(valid_out), N*DW'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_packer_unit
